quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Quadrature decoder that turns two asynchronous phase inputs (A/B) into the `up_down` direction level and one-cycle `step` pulses that drive `up_down_counter`-style counters. It also keeps its own wrapping position count and flags illegal Gray transitions. It sits between external encoder pins and the counter logic, on the same single clock domain.

## Interface
- `FILTER_LEN`, 2: consecutive stable synchronized samples required before a phase change is accepted. Legal range 1..15.
- `POS_W`, 3: width of the position count. The default matches the 3-bit counter width.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous use.
- `a` in 1: phase A, asynchronous to `clk`.
- `b` in 1: phase B, asynchronous to `clk`.
- `en` in 1: when 0, `step` and `pos` updates are suppressed. Phase tracking and error detection continue.
- `clr_err` in 1: synchronous clear of `err`.
- `step` out 1: one-cycle pulse per accepted legal transition.
- `up_down` out 1: direction of the last legal transition (1 = up, 0 = down). Held between steps.
- `pos` out POS_W: position; +1 on an up step, −1 on a down step, modulo 2^POS_W.
- `err` out 1: sticky flag set by an illegal (double-bit) transition.

## Operation
- **Synchronizer:** `a` and `b` each pass through a 2-flop synchronizer (`sa2`, `sb2`).
- **Filter, per channel:**
  - Holds filtered value `f` and counter `cnt`.
  - If `s2 == f`: `cnt <= 0`.
  - If `s2 != f` and `cnt == FILTER_LEN-1`: `f <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- **Phase state** is `{fa,fb}`. Decode compares the current state with the next state, evaluated in the same cycle the filter updates.
- **Up sequence:** 00→01→11→10→00. Any forward transition: `step=1`, `up_down=1`, `pos+1`.
- **Down sequence:** the reverse of the up sequence. Any reverse transition: `step=1`, `up_down=0`, `pos−1`.
- **Illegal transition** (both bits change in the same cycle): `err <= 1`, no step, `pos` and `up_down` unchanged. Phase state still adopts the new value.
- **No change:** `step=0`, everything else holds.
- **`en=0`:**
  - A legal transition updates the phase state only. `step` stays 0; `pos` and `up_down` hold.
  - Illegal transitions still set `err`.
- **Wrap:**
  - `pos` at 2^POS_W−1 plus an up step gives 0.
  - `pos` at 0 plus a down step gives 2^POS_W−1.
- **`err`:** set has priority over `clr_err` in the same cycle. Otherwise `clr_err=1` clears `err` at the next edge.

## Timing
- **Reset values** (while `rst=0`): sync flops 0, `fa=fb=0`, `cnt=0`, `step=0`, `up_down=0`, `pos=0`, `err=0`.
- **Reset release:** if a pin is held at 1 through release, it is accepted as a normal transition after the latency below.
- **Reset mid-operation:** all outputs drop to the reset values asynchronously; no partial step is emitted.
- **Latency:** a pin change set up before edge N appears on `sa2` after edge N+1 and is accepted into `f` at edge N+1+FILTER_LEN. `step`/`pos`/`up_down` update at that same edge.
  - FILTER_LEN=2: outputs change after edge N+3.
  - FILTER_LEN=1: outputs change after edge N+2.
- **Glitches:** a pulse shorter than FILTER_LEN synchronized cycles is rejected, and `cnt` restarts.
- **`step` width:** exactly one cycle. Back-to-back steps on consecutive cycles are legal, e.g. with FILTER_LEN=1 and the channels changing one cycle apart.
- **Simultaneous change:** two channels changing on separate pins can still be accepted in the same cycle after filtering. This counts as illegal.

## Test plan
- **Reset:** hold `rst=0` with a=b=1, then release and run 10 cycles. Required: all outputs 0 until release. The 00→11 state change after release sets `err=1`, with `pos=0` and `step` never high.
- **Up count:** FILTER_LEN=2, `en=1`; drive a/b through 00→01→11→10→00, holding each state 8 cycles. Required: 4 single-cycle `step` pulses, `up_down=1`, `pos` 0→4, each pulse 3 edges after the pin change.
- **Down wrap:** starting from `pos=0`, apply the reverse sequence for 2 steps. Required: `pos` 7 then 6, `up_down=0`, `err=0`.
- **Glitch rejection:** 1-cycle pulse on `a` with FILTER_LEN=2. Required: no `step`, `pos` unchanged, `fa` stays 0.
- **Illegal transition and clear:** toggle a and b on the same edge from 00 to 11. Required: `err=1`, `step=0`, `pos` unchanged. Then `clr_err=1` for 1 cycle gives `err=0`; asserting `clr_err` on the cycle of a second illegal transition keeps `err=1`.
- **Enable:** `en=0` with 3 up steps. Required: `step=0`, `pos` frozen. Then `en=1` with 1 up step gives `pos+1`, computed from the tracked phase with no spurious error.

Source files
------------

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_step_decoder
// Brief    : Quadrature A/B decoder with synchronizers, per-channel stability
//            filters, step/direction outputs, a wrapping position count and a
//            sticky flag for illegal Gray transitions.
// Revision : 1.0 - initial release
// ============================================================================
module quad_step_decoder #(
    parameter int FILTER_LEN = 2,   // stable samples needed to accept a change (1..15)
    parameter int POS_W      = 3    // width of the position count
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active low
    input  logic             a,
    input  logic             b,
    input  logic             en,
    input  logic             clr_err,
    output logic             step,
    output logic             up_down,
    output logic [POS_W-1:0] pos,
    output logic             err
);

    localparam int             CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    // Channel packing used throughout: bit 1 = A, bit 0 = B
    logic [1:0] pins_w;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] filt_q;
    logic [1:0] filt_d;

    assign pins_w = {a, b};

    // Two-flop synchronizer for both asynchronous phase pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= pins_w;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_filt
            logic             f_q;
            logic             f_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Accept a new level only after it has disagreed with f for FILTER_LEN samples
            always_comb begin
                f_d   = f_q;
                cnt_d = cnt_q;
                if (sync2_q[g] == f_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    f_d   = sync2_q[g];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            // Filtered level and run-length counter
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    f_q   <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    f_q   <= f_d;
                    cnt_q <= cnt_d;
                end
            end

            assign filt_q[g] = f_q;
            assign filt_d[g] = f_d;
        end
    endgenerate

    // Map a phase state onto its position in the 00->01->11->10 cycle
    function automatic logic [1:0] gray_idx(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    logic [1:0] delta_w;
    logic       fwd_w;
    logic       rev_w;
    logic       ill_w;

    // Classify the transition from the current to the about-to-be-accepted state
    always_comb begin
        delta_w = gray_idx(filt_d) - gray_idx(filt_q);
        fwd_w   = (delta_w == 2'b01);
        rev_w   = (delta_w == 2'b11);
        ill_w   = (delta_w == 2'b10);
    end

    logic             step_q;
    logic             step_d;
    logic             up_down_q;
    logic             up_down_d;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             err_q;
    logic             err_d;

    // Output next-state: steps gated by en, err set wins over clear
    always_comb begin
        step_d    = en & (fwd_w | rev_w);
        up_down_d = up_down_q;
        pos_d     = pos_q;
        err_d     = err_q;
        if (en && fwd_w) begin
            up_down_d = 1'b1;
            pos_d     = pos_q + POS_W'(1);
        end else if (en && rev_w) begin
            up_down_d = 1'b0;
            pos_d     = pos_q - POS_W'(1);
        end
        if (ill_w) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q    <= 1'b0;
            up_down_q <= 1'b0;
            pos_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            step_q    <= step_d;
            up_down_q <= up_down_d;
            pos_q     <= pos_d;
            err_q     <= err_d;
        end
    end

    assign step    = step_q;
    assign up_down = up_down_q;
    assign pos     = pos_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_step_decoder
// Brief    : Directed self-checking bench for quad_step_decoder (FILTER_LEN=2,
//            POS_W=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       en;
    logic       clr_err;
    logic       step;
    logic       up_down;
    logic [2:0] pos;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    quad_step_decoder #(
        .FILTER_LEN (2),
        .POS_W      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .en      (en),
        .clr_err (clr_err),
        .step    (step),
        .up_down (up_down),
        .pos     (pos),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new pin state, hold it 8 cycles; a pulse is due after the 4th edge
    task automatic move(input string tag, input logic na, input logic nb,
                        input logic exp_pulse, input logic [2:0] exp_pos,
                        input logic exp_ud, input logic exp_err);
        a = na;
        b = nb;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk({tag, ".step"}, step, (exp_pulse && i == 4));
            if (i == 4) begin
                chk({tag, ".pos"}, pos, exp_pos);
                chk({tag, ".ud"},  up_down, exp_ud);
            end
        end
        chk({tag, ".pos_hold"}, pos, exp_pos);
        chk({tag, ".err"}, err, exp_err);
    endtask

    initial begin
        rst = 1'b0; a = 1'b1; b = 1'b1; en = 1'b1; clr_err = 1'b0;

        // Reset held with both pins high: everything stays 0
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.step", step, 0);
            chk("rst.ud",   up_down, 0);
            chk("rst.pos",  pos, 0);
            chk("rst.err",  err, 0);
        end

        // Release: 00->11 accepted as an illegal jump
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rel.step", step, 0);
        end
        chk("rel.err", err, 1);
        chk("rel.pos", pos, 0);

        // Asynchronous reset mid-cycle clears err immediately
        a = 1'b0; b = 1'b0;
        #3 rst = 1'b0;
        #1 chk("arst.err", err, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Up count 0..4 then wrap through 7 -> 0
        move("up1", 0, 1, 1, 3'd1, 1, 0);
        move("up2", 1, 1, 1, 3'd2, 1, 0);
        move("up3", 1, 0, 1, 3'd3, 1, 0);
        move("up4", 0, 0, 1, 3'd4, 1, 0);
        move("up5", 0, 1, 1, 3'd5, 1, 0);
        move("up6", 1, 1, 1, 3'd6, 1, 0);
        move("up7", 1, 0, 1, 3'd7, 1, 0);
        move("upw", 0, 0, 1, 3'd0, 1, 0);

        // Down from 0 wraps to 7, then 6
        move("dnw", 1, 0, 1, 3'd7, 0, 0);
        move("dn2", 1, 1, 1, 3'd6, 0, 0);

        // One-cycle glitch on A is rejected
        a = 1'b0;
        tick();
        a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch.step", step, 0);
        end
        chk("glitch.pos", pos, 6);
        chk("glitch.fa", dut.filt_q, 2'b11);

        // Illegal 11 -> 00
        move("ill1", 0, 0, 0, 3'd6, 0, 1);

        // clr_err clears
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr.err", err, 0);

        // Second illegal 00 -> 11 with clr_err on the accepting edge: set wins
        a = 1'b1; b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ill2.pre_err", err, 0);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ill2.err",  err, 1);
        chk("ill2.step", step, 0);
        chk("ill2.pos",  pos, 6);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr2.err", err, 0);

        // Enable low: three up transitions tracked, nothing counted
        en = 1'b0;
        move("en0a", 1, 0, 0, 3'd6, 0, 0);
        move("en0b", 0, 0, 0, 3'd6, 0, 0);
        move("en0c", 0, 1, 0, 3'd6, 0, 0);
        en = 1'b1;
        move("en1",  1, 1, 1, 3'd7, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
